// File: rtl/store_buffer.sv
// Posted-write store buffer: queues core stores in a circular FIFO, drains them in
// order over a valid/ready bus, and forwards buffered bytes to memory-stage loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAddr,
    input  logic [31:0]                WriteData,
    input  logic [3:0]                 ByteEn,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH):0]     Count,
    input  logic [31:0]                LdAddr,
    output logic [31:0]                LdData,
    output logic [3:0]                 LdMask,
    output logic                       LdHit,
    output logic                       BusValid,
    output logic [31:0]                BusAddr,
    output logic [31:0]                BusData,
    output logic [3:0]                 BusBE,
    input  logic                       BusReady
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          enq;
    logic          deq;
    logic [AW-1:0] idx;

    assign Full     = (Count == CW'(DEPTH));
    assign Empty    = (Count == '0);
    assign BusValid = !Empty;
    assign enq      = MemWrite && (ByteEn != 4'h0) && !Full;
    assign deq      = BusValid && BusReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    // Payload storage carries no reset; only entries below Count are ever read.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= DataAddr[31:2];
            data_mem[tail] <= WriteData;
            be_mem[tail]   <= ByteEn;
        end
    end

    always_comb begin
        BusAddr = '0;
        BusData = '0;
        BusBE   = '0;
        if (BusValid) begin
            BusAddr = {addr_mem[head], 2'b00};
            BusData = data_mem[head];
            BusBE   = be_mem[head];
        end
    end

    // Walk oldest to youngest so the youngest matching store wins each lane.
    always_comb begin
        LdData = '0;
        LdMask = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if ((CW'(k) < Count) && (addr_mem[idx] == LdAddr[31:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_mem[idx][i]) begin
                        LdMask[i]       = 1'b1;
                        LdData[8*i +: 8] = data_mem[idx][8*i +: 8];
                    end
                end
            end
        end
    end

    assign LdHit = |LdMask;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic checked against a
// queue-based model of pending stores.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAddr = '0;
    logic [31:0] WriteData = '0;
    logic [3:0]  ByteEn = '0;
    logic        Full, Empty;
    logic [$clog2(DEPTH):0] Count;
    logic [31:0] LdAddr = '0;
    logic [31:0] LdData;
    logic [3:0]  LdMask;
    logic        LdHit;
    logic        BusValid;
    logic [31:0] BusAddr, BusData;
    logic [3:0]  BusBE;
    logic        BusReady = 1'b0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .DataAddr(DataAddr),
        .WriteData(WriteData), .ByteEn(ByteEn), .Full(Full), .Empty(Empty),
        .Count(Count), .LdAddr(LdAddr), .LdData(LdData), .LdMask(LdMask),
        .LdHit(LdHit), .BusValid(BusValid), .BusAddr(BusAddr), .BusData(BusData),
        .BusBE(BusBE), .BusReady(BusReady)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_t;

    store_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        store_t      h;
        e_data = '0;
        e_mask = '0;
        foreach (q[j])
            for (int i = 0; i < 4; i++)
                if (q[j].addr[31:2] == LdAddr[31:2] && q[j].be[i]) begin
                    e_mask[i]        = 1'b1;
                    e_data[8*i +: 8] = q[j].data[8*i +: 8];
                end
        h = (q.size() > 0) ? q[0] : '0;
        check({tag, ".count"},    32'(Count),    32'(q.size()));
        check({tag, ".empty"},    32'(Empty),    32'(q.size() == 0));
        check({tag, ".full"},     32'(Full),     32'(q.size() == DEPTH));
        check({tag, ".busvalid"}, 32'(BusValid), 32'(q.size() != 0));
        check({tag, ".busaddr"},  BusAddr,       {h.addr[31:2], 2'b00});
        check({tag, ".busdata"},  BusData,       h.data);
        check({tag, ".busbe"},    32'(BusBE),    32'(h.be));
        check({tag, ".ldmask"},   32'(LdMask),   32'(e_mask));
        check({tag, ".lddata"},   LdData,        e_data);
        check({tag, ".ldhit"},    32'(LdHit),    32'(e_mask != 0));
    endtask

    // Drive one cycle's inputs at the falling edge, check, then advance the model.
    task automatic step(input string tag, input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic rdy, input logic [31:0] la);
        int  sz;
        store_t s;
        @(negedge clk);
        MemWrite = mw; DataAddr = a; WriteData = d; ByteEn = be;
        BusReady = rdy; LdAddr = la;
        #1;
        check_all(tag);
        sz = q.size();
        if (sz > 0 && rdy) void'(q.pop_front());
        if (mw && be != 0 && sz < DEPTH) begin
            s.addr = a; s.data = d; s.be = be;
            q.push_back(s);
        end
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step("drain", 1'b0, 0, 0, 4'h0, 1'b1, 0);
    endtask

    initial begin
        #2;
        check("rst.busvalid", 32'(BusValid), 32'd0);
        @(negedge clk); rst = 1'b0;

        step("idle", 1'b0, 0, 0, 4'h0, 1'b0, 32'h100);
        check("idle.ldhit", 32'(LdHit), 32'd0);

        step("st100", 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h100);
        repeat (3) begin
            step("hold", 1'b0, 0, 0, 4'h0, 1'b0, 32'h100);
            check("hold.busaddr", BusAddr, 32'h100);
            check("hold.busdata", BusData, 32'hDEADBEEF);
        end
        step("pop100", 1'b0, 0, 0, 4'h0, 1'b1, 0);
        step("empty100", 1'b0, 0, 0, 4'h0, 1'b0, 0);
        check("empty100.empty", 32'(Empty), 32'd1);

        for (int k = 0; k < 5; k++)
            step("fill", 1'b1, 32'(4 * k), 32'(k + 1), 4'hF, 1'b0, 0);
        step("full", 1'b0, 0, 0, 4'h0, 1'b0, 0);
        check("full.count", 32'(Count), 32'd4);
        check("full.full", 32'(Full), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step("drainord", 1'b0, 0, 0, 4'h0, 1'b1, 0);
            check("drainord.addr", BusAddr, 32'(4 * k));
        end
        step("drained", 1'b0, 0, 0, 4'h0, 1'b0, 0);
        check("drained.valid", 32'(BusValid), 32'd0);

        step("f1", 1'b1, 32'h200, 32'h11223344, 4'hF, 1'b0, 0);
        step("f2", 1'b1, 32'h202, 32'hAABB0000, 4'hC, 1'b0, 0);
        step("fld", 1'b0, 0, 0, 4'h0, 1'b0, 32'h200);
        check("fwd.mask", 32'(LdMask), 32'hF);
        check("fwd.data", LdData, 32'hAABB3344);
        check("fwd.hit", 32'(LdHit), 32'd1);
        drain();

        step("p1", 1'b1, 32'h300, 32'h000000EE, 4'h1, 1'b0, 0);
        step("pld", 1'b0, 0, 0, 4'h0, 1'b0, 32'h300);
        check("part.mask", 32'(LdMask), 32'h1);
        check("part.data", LdData, 32'hEE);
        step("pmiss", 1'b0, 0, 0, 4'h0, 1'b0, 32'h304);
        check("part.miss", 32'(LdHit), 32'd0);
        drain();

        step("a1", 1'b1, 32'h500, 32'h1, 4'hF, 1'b0, 32'h500);
        step("a2", 1'b1, 32'h504, 32'h2, 4'hF, 1'b0, 32'h500);
        step("a3", 1'b0, 0, 0, 4'h0, 1'b0, 32'h500);
        #2 rst = 1'b1;
        #1;
        check("arst.busvalid", 32'(BusValid), 32'd0);
        check("arst.count", 32'(Count), 32'd0);
        check("arst.ldhit", 32'(LdHit), 32'd0);
        check("arst.busaddr", BusAddr, 32'd0);
        q.delete();
        @(negedge clk); rst = 1'b0;
        step("post", 1'b0, 0, 0, 4'h0, 1'b1, 32'h500);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, la;
            a  = 32'h400 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
            la = 32'h400 + (32'($urandom_range(0, 4)) << 2);
            step("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                 (n >= 200 && n < 260) ? 1'b1 : 1'($urandom_range(0, 1)), la);
        end
        step("final", 1'b0, 0, 0, 4'h0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the core's memory stage and the data bus. It captures each store (`MemWrite`, `DataAddr`, `WriteData`) into a small FIFO so that the pipeline does not wait on bus latency, then drains the stores in order over a valid/ready bus port. It also forwards buffered store data to loads from the memory stage, so a load never observes stale memory.

## Interface
- `DEPTH`, 4: number of entries; must be a power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `MemWrite`  in  1  store request from the memory stage.
- `DataAddr`  in  32  store byte address.
- `WriteData`  in  32  store data, already lane-aligned.
- `ByteEn`  in  4  byte lanes written; bit i covers `WriteData[8i+7:8i]`.
- `Full`  out  1  buffer cannot accept a store; the hazard unit stalls on it.
- `Empty`  out  1  no entries pending (used for fences/drain).
- `Count`  out  $clog2(DEPTH)+1  current occupancy.
- `LdAddr`  in  32  load address from the memory stage.
- `LdData`  out  32  forwarded store bytes; uncovered lanes are 0.
- `LdMask`  out  4  lanes of `LdData` supplied by the buffer.
- `LdHit`  out  1  `|LdMask`.
- `BusValid`  out  1  head entry is presented to the bus.
- `BusAddr`  out  32  head address, word-aligned (`[1:0]`=0).
- `BusData`  out  32  head data.
- `BusBE`  out  4  head byte enables.
- `BusReady`  in  1  bus accepts the head this cycle.

## Operation
- Circular FIFO with head/tail pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Occupancy is tracked in `Count`.
- Enqueue when `MemWrite && ByteEn!=0 && !Full`. The entry stores `{DataAddr[31:2], WriteData, ByteEn}`.
- `MemWrite` with `ByteEn==0` is ignored.
- `MemWrite` while `Full` is ignored: no entry is written and no pointer moves. Honouring `Full` is the core's responsibility.
- Dequeue when `BusValid && BusReady`. The head pointer advances.
- Simultaneous enqueue and dequeue: `Count` is unchanged and both pointers advance. This is legal at any occupancy where enqueue is permitted. When `Full`, no bypass is done: the enqueue is ignored even if a dequeue occurs in the same cycle.
- `Full` = (`Count`==DEPTH). `Empty` = (`Count`==0). `BusValid` = !`Empty`. All are decoded from registered state, with no combinational path from inputs.
- `BusAddr`/`BusData`/`BusBE` come from the head entry when `BusValid`, and are forced to 0 otherwise.
- While `BusValid && !BusReady`, all bus outputs hold stable.
- Load forwarding is combinational over all valid entries, including the head being dequeued this cycle.
  - An entry matches when its address equals `LdAddr[31:2]`.
  - For each lane i, the youngest matching entry with `ByteEn[i]` set supplies byte i.
  - `LdMask[i]` = any match covers lane i.
  - A store enqueued in the same cycle is not visible to forwarding until the next cycle.
- Storage arrays are not reset. Only pointers and `Count` are reset.

## Timing
- Reset (async assert, synchronous-edge release) values:
  - `Count`=0, `Empty`=1, `Full`=0, `BusValid`=0.
  - `BusAddr`/`BusData`/`BusBE`=0.
  - `LdHit`=0, `LdMask`=0, `LdData`=0.
- Reset asserted mid-operation discards all pending stores immediately. Bus outputs drop to 0 without waiting for `BusReady`.
- Latency: a store enqueued at edge N appears on `BusValid` in cycle N+1 (after that edge) at the earliest. A store is never presented in its enqueue cycle.
- Throughput: one enqueue and one dequeue per cycle. With `BusReady` held high, a continuous store stream never raises `Full`.
- `Full` rises in the cycle after the edge that fills the last entry. It falls in the cycle after the first dequeue from full.
- Forwarding outputs reflect the state after the most recent edge, combined with the current `LdAddr`.

## Test plan
- Reset then idle → `Empty`=1, `BusValid`=0, bus outputs 0, `LdHit`=0 for `LdAddr`=0x100.
- Store 0x100/0xDEADBEEF/BE=4'hF with `BusReady`=0 → next cycle `BusValid`=1, `BusAddr`=0x100, `BusData`=0xDEADBEEF. Outputs hold for 3 cycles. Raise `BusReady` → `Empty`=1 on the following cycle.
- `BusReady`=0, issue 5 stores to 0x0,0x4,…,0x10 (DEPTH=4) → `Full`=1 after the 4th store. The 5th store is ignored and `Count`=4. Drain with `BusReady`=1 → addresses 0x0,0x4,0x8,0xC in order, and 0x10 never appears.
- Stores 0x200/0x11223344/BE=4'hF, then 0x202/0xAABB0000/BE=4'hC, then load 0x200 → `LdMask`=4'hF, `LdData`=0xAABB3344, `LdHit`=1.
- Store 0x300/0x000000EE/BE=4'h1 only, load 0x300 → `LdMask`=4'h1, `LdData`=0x000000EE. Load 0x304 → `LdHit`=0.
- Fill to 2 entries, then assert `rst` asynchronously mid-cycle while `BusValid`=1 → `BusValid`, `Count` and `LdHit` go to 0 immediately. After release, no stale entry is presented.
